// File: rtl/sd_pkg.sv
// Shared definitions for the SD playback sequencer: state encoding and sector geometry.
package sd_pkg;
   localparam int SECTOR_BYTES      = 512;
   localparam int WORDS_PER_SEC_DEF = SECTOR_BYTES / 2;
   localparam int SEC_AW            = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_INIT = 3'd1,
      ST_CHECK     = 3'd2,
      ST_START     = 3'd3,
      ST_WAIT_BUSY = 3'd4,
      ST_READ      = 3'd5,
      ST_NEXT      = 3'd6
   } state_t;
endpackage

// File: rtl/sd_fifo_room_chk.sv
// Flags when the downstream FIFO can absorb one complete sector without overflowing.
module sd_fifo_room_chk #(
   parameter int FIFO_AW       = 10,
   parameter int FIFO_DEPTH    = 1024,
   parameter int WORDS_PER_SEC = 256
) (
   input  logic [FIFO_AW:0] fifo_wr_cnt,
   output logic             room
);
   localparam int LIMIT = FIFO_DEPTH - WORDS_PER_SEC;

   assign room = (32'(fifo_wr_cnt) <= 32'(LIMIT));
endmodule

// File: rtl/sd_play_sched.sv
// Streams a contiguous run of SD sectors into the audio FIFO, one sector read at a time,
// only starting a sector when the FIFO can hold all of it.
module sd_play_sched
   import sd_pkg::*;
#(
   parameter int WORDS_PER_SEC = WORDS_PER_SEC_DEF,
   parameter int FIFO_DEPTH    = 1024,
   parameter int FIFO_AW       = 10,
   parameter int BUSY_TIMEOUT  = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sd_init_done,
   input  logic              play_start,
   input  logic              play_stop,
   input  logic              loop_en,
   input  logic [SEC_AW-1:0] start_sec,
   input  logic [SEC_AW-1:0] sec_num,
   input  logic              rd_busy,
   input  logic              rd_val_en,
   input  logic [15:0]       rd_val_data,
   output logic              rd_start_en,
   output logic [SEC_AW-1:0] rd_sec_addr,
   input  logic [FIFO_AW:0]  fifo_wr_cnt,
   output logic              fifo_wr_en,
   output logic [15:0]       fifo_wr_data,
   output logic              playing,
   output logic              done,
   output logic              err_flag
);
   localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

   state_t            state_reg, state_next;
   logic [SEC_AW-1:0] start_sec_reg, start_sec_next;
   logic [SEC_AW-1:0] sec_num_reg, sec_num_next;
   logic [SEC_AW-1:0] sec_idx_reg, sec_idx_next;
   logic [SEC_AW-1:0] addr_reg, addr_next;
   logic [8:0]        word_cnt_reg, word_cnt_next;
   logic [TW-1:0]     timer_reg, timer_next;
   logic              stop_pend_reg, stop_pend_next;
   logic              err_reg, err_next;
   logic              done_reg, done_next;
   logic              wr_en_reg, wr_en_next;
   logic [15:0]       wr_data_reg, wr_data_next;
   logic              room;
   logic [8:0]        word_total;

   sd_fifo_room_chk #(
      .FIFO_AW       (FIFO_AW),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .WORDS_PER_SEC (WORDS_PER_SEC)
   ) u_room (
      .fifo_wr_cnt (fifo_wr_cnt),
      .room        (room)
   );

   // Includes a word arriving in the same cycle that busy drops.
   assign word_total = word_cnt_reg + 9'(rd_val_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         start_sec_reg <= '0;
         sec_num_reg   <= '0;
         sec_idx_reg   <= '0;
         addr_reg      <= '0;
         word_cnt_reg  <= '0;
         timer_reg     <= '0;
         stop_pend_reg <= 1'b0;
         err_reg       <= 1'b0;
         done_reg      <= 1'b0;
         wr_en_reg     <= 1'b0;
         wr_data_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         start_sec_reg <= start_sec_next;
         sec_num_reg   <= sec_num_next;
         sec_idx_reg   <= sec_idx_next;
         addr_reg      <= addr_next;
         word_cnt_reg  <= word_cnt_next;
         timer_reg     <= timer_next;
         stop_pend_reg <= stop_pend_next;
         err_reg       <= err_next;
         done_reg      <= done_next;
         wr_en_reg     <= wr_en_next;
         wr_data_reg   <= wr_data_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      start_sec_next = start_sec_reg;
      sec_num_next   = sec_num_reg;
      sec_idx_next   = sec_idx_reg;
      addr_next      = addr_reg;
      word_cnt_next  = word_cnt_reg;
      timer_next     = timer_reg;
      stop_pend_next = stop_pend_reg | (play_stop && (state_reg != ST_IDLE));
      err_next       = err_reg;
      done_next      = 1'b0;
      wr_en_next     = (state_reg == ST_READ) && rd_val_en;
      wr_data_next   = ((state_reg == ST_READ) && rd_val_en) ? rd_val_data : wr_data_reg;

      case (state_reg)
         ST_IDLE: begin
            if (play_start && !play_stop) begin
               if (sec_num != '0) begin
                  start_sec_next = start_sec;
                  sec_num_next   = sec_num;
                  sec_idx_next   = '0;
                  err_next       = 1'b0;
                  state_next     = ST_WAIT_INIT;
               end else begin
                  done_next = 1'b1;
               end
            end
         end
         ST_WAIT_INIT: begin
            if (sd_init_done) state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (stop_pend_reg) begin
               done_next  = 1'b1;
               state_next = ST_IDLE;
            end else if (room) begin
               addr_next  = start_sec_reg + sec_idx_reg;
               state_next = ST_START;
            end
         end
         ST_START: begin
            word_cnt_next = '0;
            timer_next    = '0;
            state_next    = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (rd_busy) begin
               state_next = ST_READ;
            end else if (timer_reg == TW'(BUSY_TIMEOUT - 1)) begin
               err_next   = 1'b1;
               done_next  = 1'b1;
               state_next = ST_IDLE;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         ST_READ: begin
            word_cnt_next = word_total;
            if (!rd_busy) begin
               if (word_total != 9'(WORDS_PER_SEC)) err_next = 1'b1;
               state_next = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (sec_idx_reg == sec_num_reg - 1'b1) begin
               if (loop_en) begin
                  sec_idx_next = '0;
                  state_next   = ST_CHECK;
               end else begin
                  done_next  = 1'b1;
                  state_next = ST_IDLE;
               end
            end else begin
               sec_idx_next = sec_idx_reg + 1'b1;
               state_next   = ST_CHECK;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (state_next == ST_IDLE) stop_pend_next = 1'b0;
   end

   assign rd_start_en  = (state_reg == ST_START);
   assign rd_sec_addr  = addr_reg;
   assign fifo_wr_en   = wr_en_reg;
   assign fifo_wr_data = wr_data_reg;
   assign playing      = (state_reg != ST_IDLE);
   assign done         = done_reg;
   assign err_flag     = err_reg;
endmodule

// File: tb/tb_sd_play_sched.sv
// Scenario bench for sd_play_sched with a reactive SD read-controller model and a FIFO scoreboard.
module tb_sd_play_sched;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sd_init_done = 1'b1;
   logic        play_start = 1'b0;
   logic        play_stop = 1'b0;
   logic        loop_en = 1'b0;
   logic [31:0] start_sec = '0;
   logic [31:0] sec_num = '0;
   logic        rd_busy = 1'b0;
   logic        rd_val_en = 1'b0;
   logic [15:0] rd_val_data = '0;
   logic [10:0] fifo_wr_cnt = '0;
   logic        rd_start_en;
   logic [31:0] rd_sec_addr;
   logic        fifo_wr_en;
   logic [15:0] fifo_wr_data;
   logic        playing;
   logic        done;
   logic        err_flag;

   int checks = 0;
   int failures = 0;

   int  model_words = 256;
   bit  model_no_busy = 1'b0;
   bit  model_active = 1'b0;
   logic [31:0] addr_q[$];
   logic [15:0] exp_q[$];
   int  start_cnt = 0, done_cnt = 0, wr_cnt = 0, data_bad = 0, overlap_cnt = 0;

   sd_play_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sd_init_done (sd_init_done),
      .play_start   (play_start),
      .play_stop    (play_stop),
      .loop_en      (loop_en),
      .start_sec    (start_sec),
      .sec_num      (sec_num),
      .rd_busy      (rd_busy),
      .rd_val_en    (rd_val_en),
      .rd_val_data  (rd_val_data),
      .rd_start_en  (rd_start_en),
      .rd_sec_addr  (rd_sec_addr),
      .fifo_wr_cnt  (fifo_wr_cnt),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .playing      (playing),
      .done         (done),
      .err_flag     (err_flag)
   );

   always #5 clk = ~clk;

   // SD read controller: busy two cycles after a start, then model_words words with random gaps.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && rd_start_en) begin
            addr_q.push_back(rd_sec_addr);
            if (!model_no_busy) begin
               model_active = 1'b1;
               repeat (2) @(negedge clk);
               rd_busy = 1'b1;
               @(negedge clk);
               for (int w = 0; w < model_words; w++) begin
                  rd_val_en   = 1'b1;
                  rd_val_data = 16'($urandom);
                  exp_q.push_back(rd_val_data);
                  @(negedge clk);
                  rd_val_en = 1'b0;
                  repeat ($urandom_range(0, 1)) @(negedge clk);
               end
               rd_busy      = 1'b0;
               model_active = 1'b0;
            end
         end
      end
   end

   // Observes DUT outputs; every FIFO write must match the next word the controller produced.
   initial begin
      forever begin
         @(negedge clk);
         if (rd_start_en) start_cnt++;
         if (done) done_cnt++;
         if (done && rd_start_en) overlap_cnt++;
         if (fifo_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) data_bad++;
            else begin
               if (fifo_wr_data !== exp_q[0]) data_bad++;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      start_cnt = 0; done_cnt = 0; wr_cnt = 0; data_bad = 0; overlap_cnt = 0;
      addr_q.delete();
      exp_q.delete();
   endtask

   task automatic start_play(input logic [31:0] ss, input logic [31:0] n);
      start_sec  = ss;
      sec_num    = n;
      play_start = 1'b1;
      step();
      play_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) step();
      checks++; if (rd_start_en !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b exp=0", rd_start_en); end
      checks++; if (rd_sec_addr !== 32'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rd_sec_addr); end
      checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0b exp=0", fifo_wr_en); end
      checks++; if (fifo_wr_data !== 16'd0) begin failures++; $display("FAIL reset_wr_data got=%0h exp=0", fifo_wr_data); end
      checks++; if (playing !== 1'b0) begin failures++; $display("FAIL reset_playing got=%0b exp=0", playing); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_flag); end
      rst_n = 1'b1;
      step();
      $display("[tb] test_reset complete");
   endtask

   task automatic test_normal(input logic [31:0] ss, input int n);
      bit ok;
      logic [31:0] e;
      clear_mon();
      fifo_wr_cnt = '0;
      start_play(ss, 32'(n));
      wait_done(n * 900 + 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL normal_done_seen got=0 exp=1"); end
      checks++; if (start_cnt !== n) begin failures++; $display("FAIL normal_starts got=%0d exp=%0d", start_cnt, n); end
      for (int i = 0; i < n && i < addr_q.size(); i++) begin
         e = ss + 32'(i);
         checks++; if (addr_q[i] !== e) begin failures++; $display("FAIL normal_addr[%0d] got=%0d exp=%0d", i, addr_q[i], e); end
      end
      checks++; if (wr_cnt !== n * 256) begin failures++; $display("FAIL normal_words got=%0d exp=%0d", wr_cnt, n * 256); end
      checks++; if (data_bad !== 0) begin failures++; $display("FAIL normal_data got=%0d bad exp=0", data_bad); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL normal_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL normal_err got=%0b exp=0", err_flag); end
      checks++; if (playing !== 1'b0) begin failures++; $display("FAIL normal_playing got=%0b exp=0", playing); end
      checks++; if (overlap_cnt !== 0) begin failures++; $display("FAIL normal_overlap got=%0d exp=0", overlap_cnt); end
      $display("[tb] test_normal start=%0d n=%0d words=%0d", ss, n, wr_cnt);
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_mon();
      fifo_wr_cnt = 11'd769;
      start_play(32'd2000000, 32'd1);
      repeat (60) step();
      checks++; if (start_cnt !== 0) begin failures++; $display("FAIL bp_held_starts got=%0d exp=0", start_cnt); end
      checks++; if (playing !== 1'b1) begin failures++; $display("FAIL bp_playing got=%0b exp=1", playing); end
      fifo_wr_cnt = 11'd768;
      repeat (2) step();
      checks++; if (start_cnt !== 1) begin failures++; $display("FAIL bp_release_starts got=%0d exp=1", start_cnt); end
      fifo_wr_cnt = '0;
      wait_done(1200, ok);
      checks++; if (!ok || wr_cnt !== 256) begin failures++; $display("FAIL bp_words got=%0d exp=256", wr_cnt); end
      $display("[tb] test_backpressure complete");
   endtask

   task automatic test_stop();
      bit ok;
      int guard;
      clear_mon();
      start_play(32'd2000000, 32'd5);
      guard = 0;
      while (wr_cnt < 100 && guard < 2000) begin step(); guard++; end
      checks++; if (wr_cnt < 100) begin failures++; $display("FAIL stop_reach100 got=%0d exp=100", wr_cnt); end
      play_stop = 1'b1;
      step();
      play_stop = 1'b0;
      wait_done(2000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stop_done_seen got=0 exp=1"); end
      checks++; if (wr_cnt !== 256) begin failures++; $display("FAIL stop_words got=%0d exp=256", wr_cnt); end
      checks++; if (start_cnt !== 1) begin failures++; $display("FAIL stop_starts got=%0d exp=1", start_cnt); end
      checks++; if (data_bad !== 0) begin failures++; $display("FAIL stop_data got=%0d bad exp=0", data_bad); end
      $display("[tb] test_stop words=%0d", wr_cnt);
   endtask

   task automatic test_loop();
      bit ok;
      int guard;
      logic [31:0] e;
      clear_mon();
      loop_en = 1'b1;
      start_play(32'd2000000, 32'd2);
      guard = 0;
      while (start_cnt < 5 && guard < 6000) begin step(); guard++; end
      play_stop = 1'b1;
      step();
      play_stop = 1'b0;
      wait_done(2000, ok);
      loop_en = 1'b0;
      checks++; if (!ok || start_cnt !== 5) begin failures++; $display("FAIL loop_starts got=%0d exp=5", start_cnt); end
      for (int i = 0; i < 5 && i < addr_q.size(); i++) begin
         e = 32'd2000000 + 32'(i % 2);
         checks++; if (addr_q[i] !== e) begin failures++; $display("FAIL loop_addr[%0d] got=%0d exp=%0d", i, addr_q[i], e); end
      end
      checks++; if (wr_cnt !== 1280) begin failures++; $display("FAIL loop_words got=%0d exp=1280", wr_cnt); end
      $display("[tb] test_loop starts=%0d", start_cnt);
   endtask

   task automatic test_short();
      bit ok;
      clear_mon();
      model_words = 255;
      start_play(32'd2000000, 32'd2);
      wait_done(2500, ok);
      model_words = 256;
      checks++; if (!ok) begin failures++; $display("FAIL short_done_seen got=0 exp=1"); end
      checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL short_err got=%0b exp=1", err_flag); end
      checks++; if (start_cnt !== 2) begin failures++; $display("FAIL short_starts got=%0d exp=2", start_cnt); end
      checks++; if (wr_cnt !== 510) begin failures++; $display("FAIL short_words got=%0d exp=510", wr_cnt); end
      repeat (5) step();
      checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL short_err_sticky got=%0b exp=1", err_flag); end
      $display("[tb] test_short words=%0d", wr_cnt);
   endtask

   task automatic test_timeout();
      int guard;
      int cyc;
      clear_mon();
      model_no_busy = 1'b1;
      start_play(32'd2000000, 32'd3);
      guard = 0;
      while (start_cnt < 1 && guard < 100) begin step(); guard++; end
      cyc = 0;
      while (done_cnt == 0 && cyc < 5000) begin step(); cyc++; end
      model_no_busy = 1'b0;
      checks++; if (cyc < 4096 || cyc > 4100) begin failures++; $display("FAIL timeout_cycles got=%0d exp=4096..4100", cyc); end
      checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL timeout_err got=%0b exp=1", err_flag); end
      checks++; if (start_cnt !== 1) begin failures++; $display("FAIL timeout_starts got=%0d exp=1", start_cnt); end
      repeat (3) step();
      checks++; if (playing !== 1'b0) begin failures++; $display("FAIL timeout_playing got=%0b exp=0", playing); end
      $display("[tb] test_timeout cycles=%0d", cyc);
   endtask

   task automatic test_zero();
      clear_mon();
      start_play(32'd5, 32'd0);
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done got=%0d exp=1", done_cnt); end
      checks++; if (playing !== 1'b0) begin failures++; $display("FAIL zero_playing got=%0b exp=0", playing); end
      repeat (10) step();
      checks++; if (start_cnt !== 0 || done_cnt !== 1) begin failures++; $display("FAIL zero_after got=%0d/%0d exp=0/1", start_cnt, done_cnt); end
      $display("[tb] test_zero complete");
   endtask

   task automatic test_same_cycle();
      clear_mon();
      start_sec  = 32'd2000000;
      sec_num    = 32'd3;
      play_start = 1'b1;
      play_stop  = 1'b1;
      step();
      play_start = 1'b0;
      play_stop  = 1'b0;
      repeat (20) step();
      checks++; if (playing !== 1'b0) begin failures++; $display("FAIL same_playing got=%0b exp=0", playing); end
      checks++; if (start_cnt !== 0 || done_cnt !== 0) begin failures++; $display("FAIL same_activity got=%0d/%0d exp=0/0", start_cnt, done_cnt); end
      $display("[tb] test_same_cycle complete");
   endtask

   task automatic test_reset_in_read();
      int guard;
      clear_mon();
      start_play(32'd2000000, 32'd3);
      guard = 0;
      while (wr_cnt < 10 && guard < 2000) begin step(); guard++; end
      checks++; if (wr_cnt < 10) begin failures++; $display("FAIL rr_reach_read got=%0d exp=10", wr_cnt); end
      rst_n = 1'b0;
      #1;
      checks++; if (rd_sec_addr !== 32'd0 || rd_start_en !== 1'b0) begin failures++; $display("FAIL rr_rd_out got=%0d/%0b exp=0/0", rd_sec_addr, rd_start_en); end
      checks++; if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 16'd0) begin failures++; $display("FAIL rr_fifo_out got=%0b/%0h exp=0/0", fifo_wr_en, fifo_wr_data); end
      checks++; if (playing !== 1'b0 || done !== 1'b0 || err_flag !== 1'b0) begin failures++; $display("FAIL rr_status got=%0b%0b%0b exp=000", playing, done, err_flag); end
      guard = 0;
      while (model_active && guard < 2000) begin step(); guard++; end
      exp_q.delete();
      rst_n = 1'b1;
      repeat (3) step();
      checks++; if (playing !== 1'b0) begin failures++; $display("FAIL rr_idle_after got=%0b exp=0", playing); end
      $display("[tb] test_reset_in_read complete");
   endtask

   initial begin
      logic [31:0] rs;
      int rn;
      test_reset();
      test_normal(32'd2000000, 3);
      test_backpressure();
      test_stop();
      test_loop();
      test_short();
      rs = $urandom;
      rn = $urandom_range(1, 4);
      test_normal(rs, rn);
      test_normal(32'hFFFF_FFFE, 3);
      test_timeout();
      test_zero();
      test_same_cycle();
      test_reset_in_read();
      test_normal(32'd2000000, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
